// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants, bank selects and host states for cic_host_mem
package cic_pkg;

   localparam int DATA_W    = 20;
   localparam int ADDR_W    = 12;
   localparam int IMG_DEPTH = 4096;
   localparam int L0_DEPTH  = 4096;
   localparam int L1_DEPTH  = 1024;
   localparam int L2_DEPTH  = 2048;

   typedef enum logic [2:0] {
      NSEL = 3'd0,
      L0K0 = 3'd1,
      L0K1 = 3'd2,
      L1K0 = 3'd3,
      L1K1 = 3'd4,
      L2F  = 3'd5
   } csel_e;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/cic_host_mem_if.sv
// rtl/cic_host_mem_if.sv - accelerator-facing image/result bus
interface cic_host_mem_if #(
   parameter int DATA_W = cic_pkg::DATA_W,
   parameter int ADDR_W = cic_pkg::ADDR_W
);
   logic              ready;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] iaddr;
   logic [DATA_W-1:0] idata;
   logic              crd;
   logic [ADDR_W-1:0] caddr_rd;
   logic [DATA_W-1:0] cdata_rd;
   logic              cwr;
   logic [ADDR_W-1:0] caddr_wr;
   logic [DATA_W-1:0] cdata_wr;
   logic [2:0]        csel;

   modport master (
      output busy, iaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
      input  ready, done, idata, cdata_rd
   );

   modport slave (
      input  busy, iaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
      output ready, done, idata, cdata_rd
   );
endinterface

// File: rtl/cic_bank_ram.sv
// rtl/cic_bank_ram.sv - one write port, two synchronous read ports, read-before-write
module cic_bank_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 20,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re_a,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic             re_b,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Read registers hold between enables so callers can treat them as held outputs.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re_a)
         rdata_a <= mem[raddr_a];
      if (re_b)
         rdata_b <= mem[raddr_b];
   end

endmodule

// File: rtl/cic_host_mem.sv
// rtl/cic_host_mem.sv - image and layer-result memory responder for the CONV accelerator
module cic_host_mem #(
   parameter int DATA_W    = cic_pkg::DATA_W,
   parameter int ADDR_W    = cic_pkg::ADDR_W,
   parameter int IMG_DEPTH = cic_pkg::IMG_DEPTH,
   parameter int L0_DEPTH  = cic_pkg::L0_DEPTH,
   parameter int L1_DEPTH  = cic_pkg::L1_DEPTH,
   parameter int L2_DEPTH  = cic_pkg::L2_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_done,
   input  logic [2:0]        host_rd_sel,
   input  logic [ADDR_W-1:0] host_rd_addr,
   output logic [DATA_W-1:0] host_rd_data,
   output logic              err,
   cic_host_mem_if.slave     acc
);
   import cic_pkg::*;

   localparam int NBANK = 6;

   // Select 0 maps to the image; only the host readback path may use it.
   function automatic int depth_of(input logic [2:0] sel);
      case (sel)
         NSEL:       return IMG_DEPTH;
         L0K0, L0K1: return L0_DEPTH;
         L1K0, L1K1: return L1_DEPTH;
         L2F:        return L2_DEPTH;
         default:    return 0;
      endcase
   endfunction

   state_e            state, state_nx;
   logic              wr_ok, rd_ok, host_ok, img_we;
   logic [2:0]        rd_sel_q, host_sel_q;
   logic              host_ok_q, img_vld_q;
   logic [DATA_W-1:0] rdata_a [8];
   logic [DATA_W-1:0] rdata_b [8];

   assign wr_ok   = acc.cwr && (acc.csel != NSEL) && (int'(acc.caddr_wr) < depth_of(acc.csel));
   assign rd_ok   = acc.crd && (acc.csel != NSEL) && (int'(acc.caddr_rd) < depth_of(acc.csel));
   assign host_ok = int'(host_rd_addr) < depth_of(host_rd_sel);
   assign img_we  = load_valid && (state == IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load_done) state_nx = ARMED;
         ARMED:   if (acc.busy) state_nx = RUN;
         RUN:     if (!acc.busy) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      acc.ready = (state == ARMED);
      acc.done  = (state == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err        <= 1'b0;
         rd_sel_q   <= NSEL;
         host_sel_q <= '0;
         host_ok_q  <= 1'b0;
         img_vld_q  <= 1'b0;
      end else begin
         if ((acc.cwr && !wr_ok) || (acc.crd && !rd_ok) || (load_valid && state != IDLE))
            err <= 1'b1;
         if (rd_ok)
            rd_sel_q <= acc.csel;
         host_sel_q <= host_rd_sel;
         host_ok_q  <= host_ok;
         if (acc.busy)
            img_vld_q <= 1'b1;
      end
   end

   // Only the bank last read legally has a fresh read register, so muxing by it holds cdata_rd.
   assign acc.cdata_rd = (rd_sel_q == NSEL) ? '0 : rdata_a[rd_sel_q];
   assign acc.idata    = img_vld_q ? rdata_a[0] : '0;
   assign host_rd_data = host_ok_q ? rdata_b[host_sel_q] : '0;

   assign rdata_a[6] = '0;
   assign rdata_a[7] = '0;
   assign rdata_b[6] = '0;
   assign rdata_b[7] = '0;

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      localparam int DEPTH = depth_of(3'(b));
      localparam int AW    = $clog2(DEPTH);

      logic              we, re_a;
      logic [AW-1:0]     waddr, raddr_a;
      logic [DATA_W-1:0] wdata;

      if (b == 0) begin : g_img
         assign we      = img_we;
         assign waddr   = load_addr[AW-1:0];
         assign wdata   = load_data;
         assign re_a    = acc.busy;
         assign raddr_a = acc.iaddr[AW-1:0];
      end else begin : g_res
         assign we      = wr_ok && (acc.csel == 3'(b));
         assign waddr   = acc.caddr_wr[AW-1:0];
         assign wdata   = acc.cdata_wr;
         assign re_a    = rd_ok && (acc.csel == 3'(b));
         assign raddr_a = acc.caddr_rd[AW-1:0];
      end

      cic_bank_ram #(
         .DEPTH (DEPTH),
         .WIDTH (DATA_W)
      ) u_ram (
         .clk     (clk),
         .we      (we),
         .waddr   (waddr),
         .wdata   (wdata),
         .re_a    (re_a),
         .raddr_a (raddr_a),
         .rdata_a (rdata_a[b]),
         .re_b    (host_rd_sel == 3'(b)),
         .raddr_b (host_rd_addr[AW-1:0]),
         .rdata_b (rdata_b[b])
      );
   end

endmodule

// File: tb/tb_cic_host_mem.sv
// tb/tb_cic_host_mem.sv - table-driven and randomized bench for cic_host_mem
module tb_cic_host_mem;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_valid = 1'b0;
   logic [11:0] load_addr = '0;
   logic [19:0] load_data = '0;
   logic        load_done = 1'b0;
   logic [2:0]  host_rd_sel = '0;
   logic [11:0] host_rd_addr = '0;
   logic [19:0] host_rd_data;
   logic        err;

   int n_cmp = 0;
   int n_fail = 0;

   cic_host_mem_if bus ();

   cic_host_mem dut (
      .clk          (clk),
      .reset        (reset),
      .load_valid   (load_valid),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_done    (load_done),
      .host_rd_sel  (host_rd_sel),
      .host_rd_addr (host_rd_addr),
      .host_rd_data (host_rd_data),
      .err          (err),
      .acc          (bus)
   );

   always #5 clk = ~clk;

   // Reference model: bank depths by select (0 = image) and plain memory arrays.
   int dep_t [8] = '{4096, 4096, 4096, 1024, 1024, 2048, 0, 0};
   int mem_m [6][4096];
   int exp_cd = 0;
   int exp_id = 0;
   int exp_host = 0;
   bit exp_err = 1'b0;

   typedef struct {
      string name;
      bit    wr;
      bit    rd;
      int    sel;
      int    aw;
      int    ar;
      int    dw;
      int    exp_rd;
      bit    exp_err;
   } vec_t;

   vec_t tbl [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%05h want 0x%05h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit legal(input int sel, input int a);
      return (sel >= 1) && (sel <= 5) && (a < dep_t[sel]);
   endfunction

   function automatic int cand(input int sel, input int idx);
      int d;
      int a;
      d = dep_t[sel];
      if (idx < 8)
         a = idx;
      else if (idx < 12)
         a = d - 12 + idx;
      else
         a = d + idx - 12;
      return a & 'hFFF;
   endfunction

   task automatic step(input bit wr, input bit rd, input int sel, input int aw, input int ar,
                       input int dw, input int hs, input int ha, input int ia);
      bit wl;
      bit rl;
      bus.cwr      = wr;
      bus.crd      = rd;
      bus.csel     = 3'(sel);
      bus.caddr_wr = 12'(aw);
      bus.caddr_rd = 12'(ar);
      bus.cdata_wr = 20'(dw);
      host_rd_sel  = 3'(hs);
      host_rd_addr = 12'(ha);
      bus.iaddr    = 12'(ia);
      wl = legal(sel, aw);
      rl = legal(sel, ar);
      if ((wr && !wl) || (rd && !rl))
         exp_err = 1'b1;
      if (rd && rl)
         exp_cd = mem_m[sel][ar];
      exp_host = (hs < 6 && ha < dep_t[hs]) ? mem_m[hs][ha] : 0;
      if (bus.busy)
         exp_id = mem_m[0][ia];
      if (wr && wl)
         mem_m[sel][aw] = dw;
      tick();
      bus.cwr = 1'b0;
      bus.crd = 1'b0;
   endtask

   initial begin
      int sel, hs, aw, ar;
      bit wr, rd;

      tbl[0]  = '{"wr_l0k0_010",     1, 0, 1, 'h010, 'h000, 'h12345, 'h00000, 0};
      tbl[1]  = '{"wr_l0k1_010",     1, 0, 2, 'h010, 'h000, 'h0BEEF, 'h00000, 0};
      tbl[2]  = '{"rd_l0k0_010",     0, 1, 1, 'h000, 'h010, 'h00000, 'h12345, 0};
      tbl[3]  = '{"rd_l0k1_010",     0, 1, 2, 'h000, 'h010, 'h00000, 'h0BEEF, 0};
      tbl[4]  = '{"wr_l1k0_005",     1, 0, 3, 'h005, 'h000, 'h00001, 'h0BEEF, 0};
      tbl[5]  = '{"rbw_l1k0_005",    1, 1, 3, 'h005, 'h005, 'h00AAA, 'h00001, 0};
      tbl[6]  = '{"rd_l1k0_005",     0, 1, 3, 'h000, 'h005, 'h00000, 'h00AAA, 0};
      tbl[7]  = '{"wr_l1k0_000",     1, 0, 3, 'h000, 'h000, 'h00777, 'h00AAA, 0};
      tbl[8]  = '{"wr_l2f_7ff",      1, 0, 5, 'h7FF, 'h000, 'h54321, 'h00AAA, 0};
      tbl[9]  = '{"rd_l2f_7ff",      0, 1, 5, 'h000, 'h7FF, 'h00000, 'h54321, 0};
      tbl[10] = '{"wr_l1k1_3ff",     1, 0, 4, 'h3FF, 'h000, 'h11111, 'h54321, 0};
      tbl[11] = '{"rd_l1k1_3ff",     0, 1, 4, 'h000, 'h3FF, 'h00000, 'h11111, 0};
      tbl[12] = '{"wr_l1k0_400_ill", 1, 0, 3, 'h400, 'h000, 'hFFFFF, 'h11111, 1};
      tbl[13] = '{"rd_l1k0_000",     0, 1, 3, 'h000, 'h000, 'h00000, 'h00777, 1};
      tbl[14] = '{"rd_sel6_ill",     0, 1, 6, 'h000, 'h000, 'h00000, 'h00777, 1};
      tbl[15] = '{"rd_sel0_ill",     0, 1, 0, 'h000, 'h005, 'h00000, 'h00777, 1};
      tbl[16] = '{"rd_l2f_800_ill",  0, 1, 5, 'h000, 'h800, 'h00000, 'h00777, 1};
      tbl[17] = '{"rd_l0k0_010_b",   0, 1, 1, 'h000, 'h010, 'h00000, 'h12345, 1};

      bus.busy = 1'b0;  bus.iaddr = '0;    bus.crd = 1'b0; bus.caddr_rd = '0;
      bus.cwr = 1'b0;   bus.caddr_wr = '0; bus.cdata_wr = '0; bus.csel = '0;

      tick();
      tick();
      check("rst_ready",     32'(bus.ready),    0);
      check("rst_idata",     32'(bus.idata),    0);
      check("rst_cdata_rd",  32'(bus.cdata_rd), 0);
      check("rst_host_rd",   32'(host_rd_data), 0);
      check("rst_done",      32'(bus.done),     0);
      check("rst_err",       32'(err),          0);
      reset = 1'b0;

      for (int k = 0; k < 4096; k++) begin
         load_valid = 1'b1;
         load_addr  = 12'(k);
         load_data  = 20'(k);
         mem_m[0][k] = k;
         tick();
      end
      load_valid = 1'b0;
      check("ready_before_load_done", 32'(bus.ready), 0);
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      check("ready_after_load_done", 32'(bus.ready), 1);

      bus.busy = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, 'h123, 'h03F);
      check("ready_drop_in_run", 32'(bus.ready),    0);
      check("idata_03f",         32'(bus.idata),    32'h0003F);
      check("host_img_123",      32'(host_rd_data), 32'h00123);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].wr, tbl[i].rd, tbl[i].sel, tbl[i].aw, tbl[i].ar, tbl[i].dw, 0, 0, 'h03F);
         check({tbl[i].name, "_cdata"}, 32'(bus.cdata_rd), tbl[i].exp_rd);
         check({tbl[i].name, "_err"},   32'(err),          32'(tbl[i].exp_err));
      end

      for (int s = 1; s <= 5; s++)
         for (int idx = 0; idx < 12; idx++)
            step(1, 0, s, cand(s, idx), 0, int'($urandom & 32'hFFFFF), 0, 0, 0);

      for (int i = 0; i < 300; i++) begin
         sel = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 7));
         hs  = int'($urandom_range(0, 7));
         wr  = 1'($urandom_range(0, 1));
         rd  = 1'($urandom_range(0, 1));
         aw  = cand(sel, int'($urandom_range(0, 13)));
         ar  = ($urandom_range(0, 3) == 0) ? aw : cand(sel, int'($urandom_range(0, 13)));
         step(wr, rd, sel, aw, ar, int'($urandom & 32'hFFFFF), hs,
              cand(hs, int'($urandom_range(0, 13))), int'($urandom_range(0, 4095)));
         check("rand_cdata_rd", 32'(bus.cdata_rd), exp_cd);
         check("rand_host_rd",  32'(host_rd_data), exp_host);
         check("rand_idata",    32'(bus.idata),    exp_id);
         check("rand_err",      32'(err),          32'(exp_err));
      end

      step(0, 0, 0, 0, 0, 0, 0, 0, 'h123);
      check("idata_123", 32'(bus.idata), 32'h00123);
      bus.busy  = 1'b0;
      bus.iaddr = '0;
      tick();
      check("done_pulse",      32'(bus.done),  1);
      check("ready_in_done",   32'(bus.ready), 0);
      tick();
      check("done_one_cycle",  32'(bus.done),  0);
      check("idata_hold_idle", 32'(bus.idata), 32'h00123);
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      check("rearm_ready", 32'(bus.ready), 1);
      bus.busy = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rearm_run_ready", 32'(bus.ready), 0);
      check("rearm_idata_0",   32'(bus.idata), 0);

      reset = 1'b1;
      #1;
      check("midrun_rst_ready", 32'(bus.ready),    0);
      check("midrun_rst_done",  32'(bus.done),     0);
      check("midrun_rst_err",   32'(err),          0);
      check("midrun_rst_cdata", 32'(bus.cdata_rd), 0);
      check("midrun_rst_idata", 32'(bus.idata),    0);
      tick();
      reset = 1'b0;
      host_rd_sel  = 3'd1;
      host_rd_addr = 12'h010;
      tick();
      check("host_l0k0_010_after_rst", 32'(host_rd_data), 32'h12345);
      check("ready_needs_load_done",   32'(bus.ready),    0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
